// File: rtl/clock_monitor_pkg.sv
// Shared defaults and result type for the clock monitor.
package clock_monitor_pkg;

   // Default width of every cycle counter and measurement output.
   localparam int CNT_W_DEF = 16;

   // Saturation value of a default-width counter; reaching it means the
   // monitored clock has been silent for the whole counter range.
   localparam logic [CNT_W_DEF-1:0] CNT_MAX = {CNT_W_DEF{1'b1}};

   // One completed measurement window.
   typedef struct packed {
      logic [CNT_W_DEF-1:0] period;
      logic [CNT_W_DEF-1:0] high_time;
      logic [CNT_W_DEF-1:0] period_min;
      logic [CNT_W_DEF-1:0] period_max;
      logic [CNT_W_DEF-1:0] jitter;
      logic                 err;
   } meas_t;

endpackage

// File: rtl/clock_monitor_sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous level, followed by a delay
// flop that turns the synchronized level into rise/fall strobes.
module sync_edge_detect
   import clock_monitor_pkg::*;
#(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic s,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;
   logic              d_q;
   logic              d_d;

   // Shift the async input through the synchronizer chain and delay flop.
   always_comb begin
      sync_d = {sync_q[STAGES-2:0], din};
      d_d    = sync_q[STAGES-1];
   end

   // Synchronizer and delay registers; synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q <= '0;
         d_q    <= 1'b0;
      end else begin
         sync_q <= sync_d;
         d_q    <= d_d;
      end
   end

   assign s    = sync_q[STAGES-1];
   assign rise = sync_q[STAGES-1] & ~d_q;
   assign fall = ~sync_q[STAGES-1] & d_q;

endmodule

// File: rtl/clock_monitor.sv
// Monitors a generated clock sampled as data in the clk domain: measures
// period, high time, min/max period and jitter over WINDOW periods, flags
// out-of-range periods and reports a lost clock.
module clock_monitor
   import clock_monitor_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEF,
   parameter int SYNC_STAGES = 2,
   parameter int WINDOW      = 8,
   parameter int MIN_PERIOD  = 4,
   parameter int MAX_PERIOD  = 1000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             mon_clk_in,
   output logic             meas_valid,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic [CNT_W-1:0] period_min,
   output logic [CNT_W-1:0] period_max,
   output logic [CNT_W-1:0] jitter,
   output logic             err_range,
   output logic             timeout
);

   localparam logic [CNT_W-1:0]  ALL1     = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]  ONE      = CNT_W'(1);
   localparam logic [CNT_W-1:0]  MIN_P    = CNT_W'(MIN_PERIOD);
   localparam logic [CNT_W-1:0]  MAX_P    = CNT_W'(MAX_PERIOD);
   // Window counter runs 0..WINDOW-1; the last measurement closes the window.
   localparam int                WCNT_W   = (WINDOW < 2) ? 1 : $clog2(WINDOW);
   localparam logic [WCNT_W-1:0] WIN_LAST = WCNT_W'(WINDOW - 1);
   localparam logic [WCNT_W-1:0] WCNT_ONE = WCNT_W'(1);

   logic s_s;
   logic rise_s;
   logic fall_unused_s;

   sync_edge_detect #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (mon_clk_in),
      .s     (s_s),
      .rise  (rise_s),
      .fall  (fall_unused_s)
   );

   logic [CNT_W-1:0]  pcnt_q, pcnt_d;
   logic [CNT_W-1:0]  hcnt_q, hcnt_d;
   logic              armed_q, armed_d;
   logic [WCNT_W-1:0] wcnt_q, wcnt_d;
   logic [CNT_W-1:0]  wmin_q, wmin_d;
   logic [CNT_W-1:0]  wmax_q, wmax_d;
   logic              werr_q, werr_d;
   logic              meas_valid_q, meas_valid_d;
   logic [CNT_W-1:0]  period_q, period_d;
   logic [CNT_W-1:0]  high_time_q, high_time_d;
   logic [CNT_W-1:0]  period_min_q, period_min_d;
   logic [CNT_W-1:0]  period_max_q, period_max_d;
   logic [CNT_W-1:0]  jitter_q, jitter_d;
   logic              err_range_q, err_range_d;
   logic              timeout_q, timeout_d;

   logic [CNT_W-1:0]  new_min_s;
   logic [CNT_W-1:0]  new_max_s;
   logic              new_err_s;

   // Window statistics as they would be after folding in the current period.
   always_comb begin
      new_min_s = (pcnt_q < wmin_q) ? pcnt_q : wmin_q;
      new_max_s = (pcnt_q > wmax_q) ? pcnt_q : wmax_q;
      new_err_s = werr_q | (pcnt_q < MIN_P) | (pcnt_q > MAX_P);
   end

   // Counters, arming, window accumulation and result publication.
   always_comb begin
      pcnt_d       = pcnt_q;
      hcnt_d       = hcnt_q;
      armed_d      = armed_q;
      wcnt_d       = wcnt_q;
      wmin_d       = wmin_q;
      wmax_d       = wmax_q;
      werr_d       = werr_q;
      meas_valid_d = 1'b0;
      period_d     = period_q;
      high_time_d  = high_time_q;
      period_min_d = period_min_q;
      period_max_d = period_max_q;
      jitter_d     = jitter_q;
      err_range_d  = err_range_q;
      timeout_d    = timeout_q;

      if (!enable) begin
         // Disabled: drop all partial state, keep published results.
         pcnt_d  = '0;
         hcnt_d  = '0;
         armed_d = 1'b0;
         wcnt_d  = '0;
         wmin_d  = ALL1;
         wmax_d  = '0;
         werr_d  = 1'b0;
      end else begin
         pcnt_d = (pcnt_q == ALL1) ? pcnt_q : pcnt_q + ONE;
         if (s_s) begin
            hcnt_d = (hcnt_q == ALL1) ? hcnt_q : hcnt_q + ONE;
         end else begin
            hcnt_d = hcnt_q;
         end

         if (rise_s) begin
            // A rise starts a new period; pre-load counts are the old period.
            pcnt_d    = ONE;
            hcnt_d    = ONE;
            armed_d   = 1'b1;
            timeout_d = 1'b0;
            if (armed_q) begin
               if (wcnt_q == WIN_LAST) begin
                  // Publish and restart the window in the same cycle.
                  meas_valid_d = 1'b1;
                  period_d     = pcnt_q;
                  high_time_d  = hcnt_q;
                  period_min_d = new_min_s;
                  period_max_d = new_max_s;
                  jitter_d     = new_max_s - new_min_s;
                  err_range_d  = new_err_s;
                  wcnt_d       = '0;
                  wmin_d       = ALL1;
                  wmax_d       = '0;
                  werr_d       = 1'b0;
               end else begin
                  wcnt_d = wcnt_q + WCNT_ONE;
                  wmin_d = new_min_s;
                  wmax_d = new_max_s;
                  werr_d = new_err_s;
               end
            end else begin
               // First rise after reset/enable/timeout only arms.
               wcnt_d = wcnt_q;
            end
         end else if (pcnt_q == ALL1) begin
            // Clock lost: flag it, disarm and throw away the partial window.
            timeout_d = 1'b1;
            armed_d   = 1'b0;
            wcnt_d    = '0;
            wmin_d    = ALL1;
            wmax_d    = '0;
            werr_d    = 1'b0;
         end else begin
            armed_d = armed_q;
         end
      end
   end

   // All state and output registers; synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pcnt_q       <= '0;
         hcnt_q       <= '0;
         armed_q      <= 1'b0;
         wcnt_q       <= '0;
         wmin_q       <= ALL1;
         wmax_q       <= '0;
         werr_q       <= 1'b0;
         meas_valid_q <= 1'b0;
         period_q     <= '0;
         high_time_q  <= '0;
         period_min_q <= '0;
         period_max_q <= '0;
         jitter_q     <= '0;
         err_range_q  <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         pcnt_q       <= pcnt_d;
         hcnt_q       <= hcnt_d;
         armed_q      <= armed_d;
         wcnt_q       <= wcnt_d;
         wmin_q       <= wmin_d;
         wmax_q       <= wmax_d;
         werr_q       <= werr_d;
         meas_valid_q <= meas_valid_d;
         period_q     <= period_d;
         high_time_q  <= high_time_d;
         period_min_q <= period_min_d;
         period_max_q <= period_max_d;
         jitter_q     <= jitter_d;
         err_range_q  <= err_range_d;
         timeout_q    <= timeout_d;
      end
   end

   assign meas_valid = meas_valid_q;
   assign period     = period_q;
   assign high_time  = high_time_q;
   assign period_min = period_min_q;
   assign period_max = period_max_q;
   assign jitter     = jitter_q;
   assign err_range  = err_range_q;
   assign timeout    = timeout_q;

endmodule
